// File: rtl/ram_wstrb_ctrl.sv
// ram_wstrb_ctrl
//   Byte write-strobe front end for the word-only data RAM. Full-word writes
//   and reads pass straight through to the RAM; partial writes are turned into
//   a read-modify-write on the RAM. One transaction is in flight at a time.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | ready for a request; full/empty writes complete from here
//   RD_WAIT  | read issued, waiting for ram_rdata_valid
//   RMW_WAIT | partial write: old word read issued, waiting for valid
//   RMW_WR   | partial write: merged word written back to the RAM
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   cpu_req/we/addr/wdata/wstrb       CPU request (held until accepted)
//   cpu_ready, cpu_done, cpu_rdata    accept, completion pulse, read data
//   ram_addr/we/wdata                 RAM word address, write enable, data
//   ram_rdata, ram_rdata_valid        RAM read return
module ram_wstrb_ctrl #(
   parameter int RAM_ADDR_WIDTH = 10
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cpu_req,
   input  logic                      cpu_we,
   input  logic [31:0]               cpu_addr,
   input  logic [31:0]               cpu_wdata,
   input  logic [3:0]                cpu_wstrb,
   output logic                      cpu_ready,
   output logic                      cpu_done,
   output logic [31:0]               cpu_rdata,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic                      ram_we,
   output logic [31:0]               ram_wdata,
   input  logic [31:0]               ram_rdata,
   input  logic                      ram_rdata_valid
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RMW_WAIT = 2'd2,
      RMW_WR   = 2'd3
   } state_t;

   state_t                    state;
   state_t                    next_state;
   logic [RAM_ADDR_WIDTH-1:0] addr_q;
   logic [31:0]               wdata_q;
   logic [3:0]                wstrb_q;
   logic [31:0]               merge_q;
   logic [31:0]               merge_c;
   logic                      accept;
   logic                      full_wr;
   logic                      empty_wr;
   logic                      ram_we_c;
   logic                      done_c;

   // Upper address bits alias and the byte offset is ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{cpu_addr[31:RAM_ADDR_WIDTH+2], cpu_addr[1:0]};

   assign cpu_ready = (state == IDLE);
   assign accept    = cpu_req & cpu_ready;
   assign full_wr   = cpu_we & (cpu_wstrb == 4'hF);
   assign empty_wr  = cpu_we & (cpu_wstrb == 4'h0);

   always_comb begin
      merge_c = '0;
      for (int i = 0; i < 4; i++) begin
         merge_c[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : ram_rdata[8*i +: 8];
      end
   end

   always_comb begin
      next_state = state;
      ram_we_c   = 1'b0;
      ram_addr   = addr_q;
      ram_wdata  = merge_q;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            ram_addr  = cpu_addr[RAM_ADDR_WIDTH+1:2];
            ram_wdata = cpu_wdata;
            if (accept) begin
               if (!cpu_we) begin
                  next_state = RD_WAIT;
               end else if (full_wr) begin
                  ram_we_c = 1'b1;
                  done_c   = 1'b1;
               end else if (empty_wr) begin
                  done_c = 1'b1;
               end else begin
                  next_state = RMW_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (ram_rdata_valid) begin
               done_c     = 1'b1;
               next_state = IDLE;
            end
         end
         RMW_WAIT: begin
            if (ram_rdata_valid) begin
               next_state = RMW_WR;
            end
         end
         RMW_WR: begin
            ram_we_c   = 1'b1;
            done_c     = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Write enable must never reach the RAM while reset is held.
   assign ram_we = ram_we_c & reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cpu_done  <= 1'b0;
         cpu_rdata <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         merge_q   <= '0;
      end else begin
         state    <= next_state;
         cpu_done <= done_c;
         if (accept) begin
            addr_q  <= cpu_addr[RAM_ADDR_WIDTH+1:2];
            wdata_q <= cpu_wdata;
            wstrb_q <= cpu_wstrb;
         end
         if (state == RD_WAIT && ram_rdata_valid) begin
            cpu_rdata <= ram_rdata;
         end
         if (state == RMW_WAIT && ram_rdata_valid) begin
            merge_q <= merge_c;
         end
      end
   end

endmodule

// File: tb/tb_ram_wstrb_ctrl.sv
module tb_ram_wstrb_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [3:0]  cpu_wstrb = '0;
   logic        cpu_ready;
   logic        cpu_done;
   logic [31:0] cpu_rdata;
   logic [9:0]  ram_addr;
   logic        ram_we;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic        ram_rdata_valid = 1'b0;
   logic        stall = 1'b0;

   logic [31:0] mem [0:1023];

   int checks = 0;
   int fails  = 0;

   ram_wstrb_ctrl #(.RAM_ADDR_WIDTH(10)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cpu_req         (cpu_req),
      .cpu_we          (cpu_we),
      .cpu_addr        (cpu_addr),
      .cpu_wdata       (cpu_wdata),
      .cpu_wstrb       (cpu_wstrb),
      .cpu_ready       (cpu_ready),
      .cpu_done        (cpu_done),
      .cpu_rdata       (cpu_rdata),
      .ram_addr        (ram_addr),
      .ram_we          (ram_we),
      .ram_wdata       (ram_wdata),
      .ram_rdata       (ram_rdata),
      .ram_rdata_valid (ram_rdata_valid)
   );

   always #5 clk = ~clk;

   // Word RAM with one-cycle read latency; valid can be held off via stall.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata       <= mem[ram_addr];
      ram_rdata_valid <= !stall;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts and ends 1 time unit after a rising edge.
   task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      bit seen;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = addr;
      @(negedge clk);
      chk({tag, " rd_accept_we"}, {31'd0, ram_we}, 32'd0);
      chk({tag, " rd_addr"}, {22'd0, ram_addr}, {22'd0, addr[11:2]});
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      chk({tag, " rd_wait_done"}, {31'd0, cpu_done}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         @(negedge clk);
         if (cpu_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, " rd_done"}, {31'd0, seen}, 32'd1);
      chk({tag, " rd_data"}, cpu_rdata, exp);
      chk({tag, " rd_ready"}, {31'd0, cpu_ready}, 32'd1);
      tick();
   endtask

   initial begin
      bit seen;
      for (int i = 0; i < 1024; i++) mem[i] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
      chk("rst_done",  {31'd0, cpu_done},  32'd0);
      chk("rst_we",    {31'd0, ram_we},    32'd0);
      chk("rst_rdata", cpu_rdata,          32'h0);
      tick();
      reset_n = 1'b1;
      tick();

      // Full write 0x10 <- DEADBEEF
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10;
      cpu_wdata = 32'hDEADBEEF; cpu_wstrb = 4'hF;
      @(negedge clk);
      chk("fw_we",    {31'd0, ram_we},    32'd1);
      chk("fw_addr",  {22'd0, ram_addr},  32'd4);
      chk("fw_wdata", ram_wdata,          32'hDEADBEEF);
      chk("fw_done0", {31'd0, cpu_done},  32'd0);
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("fw_done1", {31'd0, cpu_done},  32'd1);
      chk("fw_we1",   {31'd0, ram_we},    32'd0);
      tick();
      @(negedge clk);
      chk("fw_done_once", {31'd0, cpu_done}, 32'd0);
      tick();
      do_read(32'h10, 32'hDEADBEEF, "rd1");

      // Partial write byte 1 -> DEAD55EF
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10;
      cpu_wdata = 32'h00005500; cpu_wstrb = 4'b0010;
      @(negedge clk);
      chk("pw_c0_we",    {31'd0, ram_we},    32'd0);
      chk("pw_c0_ready", {31'd0, cpu_ready}, 32'd1);
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("pw_c1_we",    {31'd0, ram_we},    32'd0);
      chk("pw_c1_ready", {31'd0, cpu_ready}, 32'd0);
      tick();
      @(negedge clk);
      chk("pw_c2_we",    {31'd0, ram_we},    32'd1);
      chk("pw_c2_addr",  {22'd0, ram_addr},  32'd4);
      chk("pw_c2_wdata", ram_wdata,          32'hDEAD55EF);
      tick();
      @(negedge clk);
      chk("pw_c3_done",  {31'd0, cpu_done},  32'd1);
      chk("pw_c3_ready", {31'd0, cpu_ready}, 32'd1);
      chk("pw_c3_we",    {31'd0, ram_we},    32'd0);
      tick();
      do_read(32'h10, 32'hDEAD55EF, "rd2");

      // Back-to-back full writes to words 0,1,2
      for (int k = 0; k < 3; k++) begin
         cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'(k * 4);
         cpu_wdata = 32'h11111111 * (k + 1); cpu_wstrb = 4'hF;
         @(negedge clk);
         chk("b2b_we",    {31'd0, ram_we},    32'd1);
         chk("b2b_addr",  {22'd0, ram_addr},  32'(k));
         chk("b2b_ready", {31'd0, cpu_ready}, 32'd1);
         chk("b2b_done",  {31'd0, cpu_done},  (k == 0) ? 32'd0 : 32'd1);
         tick();
      end
      cpu_req = 1'b0;
      @(negedge clk);
      chk("b2b_done_last", {31'd0, cpu_done}, 32'd1);
      tick();
      do_read(32'h8, 32'h33333333, "rd_b2b");

      // Partial write with RAM valid held low for 3 cycles
      stall = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10;
      cpu_wdata = 32'hAABBCCDD; cpu_wstrb = 4'b1001;
      tick();
      cpu_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_we",   {31'd0, ram_we},   32'd0);
         chk("stall_done", {31'd0, cpu_done}, 32'd0);
         tick();
      end
      stall = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ram_we) begin
            seen = 1'b1;
            break;
         end
         chk("stall_pre_done", {31'd0, cpu_done}, 32'd0);
         tick();
      end
      chk("stall_we_seen", {31'd0, seen}, 32'd1);
      chk("stall_wdata",   ram_wdata,     32'hAAAD55DD);
      tick();
      @(negedge clk);
      chk("stall_done1", {31'd0, cpu_done}, 32'd1);
      chk("stall_we1",   {31'd0, ram_we},   32'd0);
      tick();
      do_read(32'h10, 32'hAAAD55DD, "rd_stall");

      // Reset during RMW_WAIT aborts the write
      stall = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10;
      cpu_wdata = 32'h12345678; cpu_wstrb = 4'b0100;
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("abort_wait_ready", {31'd0, cpu_ready}, 32'd0);
      tick();
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_ready", {31'd0, cpu_ready}, 32'd1);
      chk("abort_we",    {31'd0, ram_we},    32'd0);
      chk("abort_done",  {31'd0, cpu_done},  32'd0);
      tick();
      @(negedge clk);
      chk("abort_we2", {31'd0, ram_we}, 32'd0);
      tick();
      stall = 1'b0;
      reset_n = 1'b1;
      tick();
      @(negedge clk);
      chk("post_rst_ready", {31'd0, cpu_ready}, 32'd1);
      chk("post_rst_done",  {31'd0, cpu_done},  32'd0);
      tick();
      // Aliased address 0x1013 maps to word 4
      do_read(32'h00001013, 32'hAAAD55DD, "rd_alias");

      // Empty-strobe write: completes, never writes
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10;
      cpu_wdata = 32'hFFFFFFFF; cpu_wstrb = 4'h0;
      @(negedge clk);
      chk("empty_we0", {31'd0, ram_we}, 32'd0);
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("empty_done",  {31'd0, cpu_done},  32'd1);
      chk("empty_we1",   {31'd0, ram_we},    32'd0);
      chk("empty_ready", {31'd0, cpu_ready}, 32'd1);
      tick();
      do_read(32'h10, 32'hAAAD55DD, "rd_empty");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
